// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and default width shared by the serial adder
package serial_add_pkg;
    localparam int SA_WIDTH = 8;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: 1-bit full adder, the only arithmetic in the serial adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequenced around one full_adder
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-2:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d, ovf_q, ovf_d;
    logic               fa_sum, fa_cout;
    logic [WIDTH-1:0]   res;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // new sum bit enters at the MSB; after the final bit res is the full sum
    assign res       = {fa_sum, sh_q};
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = state_q == S_DONE;
    assign busy      = state_q == S_RUN;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // next-state: accept operands, shift one bit per cycle, hold result until taken
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                state_d = S_RUN;
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                cnt_d   = '0;
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sh_d    = res[WIDTH-1:1];
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = cnt_q;
                    sum_d   = res;
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                end
            end
            S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: random and directed checks of the serial adder against an arithmetic model
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, cout8, ovf8, busy8;
    logic [7:0] sum8;
    logic       in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       in_ready4, out_valid4, cout4, ovf4, busy4;
    logic [3:0] sum4;
    int         n_cmp = 0;
    int         n_err = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum} from integer arithmetic on unsigned and signed views
    function automatic logic [31:0] ref_add(input int w, input int unsigned ta, input int unsigned tb, input int tc);
        int unsigned u;
        int sa, sb, s;
        logic o;
        u  = ta + tb + tc;
        sa = (ta >= (1 << (w - 1))) ? int'(ta) - (1 << w) : int'(ta);
        sb = (tb >= (1 << (w - 1))) ? int'(tb) - (1 << w) : int'(tb);
        s  = sa + sb + tc;
        o  = (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
        return (32'(o) << (w + 1)) | 32'(u);
    endfunction

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input int hold, input bit junk);
        int k;
        logic [31:0] e;
        e = ref_add(8, ta, tb, tc);
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1; out_ready8 = (hold == 0);
        check("in_ready8", in_ready8, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = junk;
        check("busy8", busy8, 1);
        k = 0;
        while (!out_valid8 && k < 40) begin
            if (junk) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("lat8", k, 8);
        check("res8", {ovf8, cout8, sum8}, e);
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_res8", {ovf8, cout8, sum8}, e);
            check("hold_valid8", out_valid8, 1);
            check("hold_ready8", in_ready8, 0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("drop8", out_valid8, 0);
        out_ready8 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int k;
        bit hs;
        logic [31:0] e;
        e = ref_add(4, ta, tb, tc);
        @(negedge clk);
        a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1; out_ready4 = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 20) begin
            out_ready4 = 1'($urandom);
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("lat4", k, 4);
        hs = 1'b0;
        for (int j = 0; j < 64 && !hs; j++) begin
            check("res4", {ovf4, cout4, sum4}, e);
            out_ready4 = 1'($urandom);
            hs = out_ready4;
            @(posedge clk);
            @(negedge clk);
        end
        check("drop4", out_valid4, 0);
        out_ready4 = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready8", in_ready8, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready8", in_ready8, 1);
        check("post_rst_busy8", busy8, 0);
        check("post_rst_valid8", out_valid8, 0);
        check("post_rst_res8", {ovf8, cout8, sum8}, 0);
        op8(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        op8(8'h80, 8'h80, 1'b0, 0, 1'b0);
        op8(8'hA5, 8'h17, 1'b1, 5, 1'b1);
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy8", busy8, 0);
        check("abort_valid8", out_valid8, 0);
        check("abort_ready8", in_ready8, 1);
        check("abort_res8", {ovf8, cout8, sum8}, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_valid8", out_valid8, 0);
        end
        out_ready8 = 1'b0;
        op8(8'h12, 8'h34, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    op4(4'(ia), 4'(ib), 1'(ic));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
